ex_muldiv: RTL and testbench

- EX-stage iterative multiply/divide unit. Fed by the ID/EX pipeline register outputs after forwarding: operands from ReadData1/ReadData2, and op decode.
- Owns the HI/LO registers. Runs MULT/MULTU/DIV/DIVU in the background over 33 cycles.
- Raises a stall into the ID/EX register's ID_Stall input only when a later instruction needs HI/LO or the unit.

---
 rtl/ex_muldiv.sv | 169 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit that owns HI/LO.
// state  | meaning
// S_IDLE | ready for a new op or MTHI/MTLO; S_CALC | one shift-add or restoring-divide step per cycle; S_FIX | sign fix-up, HI/LO write
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hilo_read,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic                   sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opb_q, opb_d;
    logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic                   done_q, done_d;

    logic [WIDTH-1:0]       abs_a, abs_b;
    logic [WIDTH:0]         mul_sum, rem_sh, rem_diff;
    logic                   rem_ge;
    logic [2*WIDTH-1:0]     mul_next, div_next, prod_neg;
    logic                   is_signed;

    always_comb begin
        abs_a     = (src_a[WIDTH-1] && !op[0]) ? -src_a : src_a;
        abs_b     = (src_b[WIDTH-1] && !op[0]) ? -src_b : src_b;
        is_signed = !op_q[0];

        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

        // The shifted partial remainder can need WIDTH+1 bits when the divisor is large.
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        rem_ge   = rem_sh >= {1'b0, opb_q};
        rem_diff = rem_sh - {1'b0, opb_q};
        div_next = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};

        prod_neg = -acc_q;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!flush) begin
                    if (hi_we) hi_d = hilo_wdata;
                    if (lo_we) lo_d = hilo_wdata;
                    if (start) begin
                        op_d  = op;
                        sa_d  = src_a[WIDTH-1];
                        sb_d  = src_b[WIDTH-1];
                        cnt_d = '0;
                        dz_d  = op[1] && (src_b == '0);
                        if (op[1] && (src_b == '0)) begin
                            acc_d   = {{WIDTH{1'b0}}, src_a};
                            opb_d   = '0;
                            state_d = S_FIX;
                        end else if (op[1]) begin
                            acc_d   = {{WIDTH{1'b0}}, abs_a};
                            opb_d   = abs_b;
                            state_d = S_CALC;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, abs_b};
                            opb_d   = abs_a;
                            state_d = S_CALC;
                        end
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = op_q[1] ? div_next : mul_next;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = acc_q[WIDTH-1:0];
                    end else if (op_q[1]) begin
                        lo_d = (is_signed && (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = (is_signed && sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end else if (is_signed && (sa_q ^ sb_q)) begin
                        {hi_d, lo_d} = prod_neg;
                    end else begin
                        {hi_d, lo_d} = acc_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;
    assign busy  = (state_q != S_IDLE);
    assign stall = busy && (start || hilo_read || hi_we || lo_we);
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed plus randomized checks of ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, hilo_read, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, hilo_wdata;
    logic [31:0] hi, lo;
    logic        busy, stall, done;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mhi = '0, mlo = '0;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .hilo_read(hilo_read), .hi_we(hi_we), .lo_we(lo_we),
        .hilo_wdata(hilo_wdata), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results straight from the arithmetic definitions.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      x, y;
        logic [63:0] up;
        x = longint'($signed(a));
        y = longint'($signed(b));
        case (o)
            2'd0: {mhi, mlo} = 64'(x * y);
            2'd1: begin up = {32'b0, a} * {32'b0, b}; {mhi, mlo} = up; end
            2'd2: if (b == 0) begin mlo = '1; mhi = a; end
                  else begin mlo = 32'(x / y); mhi = 32'(x % y); end
            default: if (b == 0) begin mlo = '1; mhi = a; end
                     else begin mlo = a / b; mhi = a % b; end
        endcase
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        tick();
        start = 1'b0;
    endtask

    // Entered in cycle T+1; expects done exactly at T+lat with the model's HI/LO.
    task automatic wait_done(input int lat, input string tag);
        int n, berr;
        n = 1; berr = 0;
        while (n < 40 && done !== 1'b1) begin
            if (busy !== 1'b1) berr++;
            tick();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " busy_during"}, 64'(berr), 64'd0);
        chk({tag, " hi"}, {32'b0, hi}, {32'b0, mhi});
        chk({tag, " lo"}, {32'b0, lo}, {32'b0, mlo});
        chk({tag, " busy_after"}, {63'b0, busy}, 64'd0);
        tick();
        chk({tag, " done_pulse"}, {63'b0, done}, 64'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        model(o, a, b);
        issue(o, a, b);
        wait_done((o[1] && b == 0) ? 2 : 34, tag);
    endtask

    initial begin
        int n, err, dcnt;
        logic [1:0]  ro;
        logic [31:0] ra, rb, phi, plo;
        rst = 1'b1; start = 0; flush = 0; hilo_read = 0; hi_we = 0; lo_we = 0;
        op = '0; src_a = '0; src_b = '0; hilo_wdata = '0;
        #3 rst = 1'b0;
        #1;
        chk("rst hi", {32'b0, hi}, 64'd0);
        chk("rst lo", {32'b0, lo}, 64'd0);
        chk("rst busy", {63'b0, busy}, 64'd0);
        chk("rst done", {63'b0, done}, 64'd0);
        chk("rst stall", {63'b0, stall}, 64'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'd3, 32'd100, 32'd7, "divu_100_7");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_neg1");
        run_op(2'd3, 32'd5, 32'd0, "divu_by_zero");
        run_op(2'd2, 32'hFFFF_FFF0, 32'd0, "div_by_zero_neg");
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");

        // start killed by flush in the same cycle is not accepted
        start = 1'b1; flush = 1'b1; op = 2'd0; src_a = 32'd9; src_b = 32'd9;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start busy", {63'b0, busy}, 64'd0);

        hi_we = 1'b1; hilo_wdata = 32'h1234_5678;
        tick();
        hi_we = 1'b0; mhi = 32'h1234_5678;
        chk("mthi idle", {32'b0, hi}, {32'b0, mhi});

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 3 == 0) rb = rb & 32'h0000_00FF;
            run_op(ro, ra, rb, $sformatf("rand%0d", i));
        end

        // MFHI/MFLO stalls until the unit is idle again
        model(2'd0, 32'd3, 32'd4);
        issue(2'd0, 32'd3, 32'd4);
        repeat (4) tick();
        hilo_read = 1'b1;
        #1;
        err = 0;
        for (int c = 5; c < 33; c++) begin
            if (stall !== 1'b1) err++;
            tick();
        end
        chk("read stall_run", 64'(err), 64'd0);
        chk("read stall_T33", {63'b0, stall}, 64'd1);
        tick();
        chk("read stall_T34", {63'b0, stall}, 64'd0);
        chk("read lo", {32'b0, lo}, 64'd12);
        chk("read done", {63'b0, done}, 64'd1);
        hilo_read = 1'b0;
        tick();

        // MTLO while busy is held off and lands once idle
        ra = $urandom; rb = $urandom;
        model(2'd1, ra, rb);
        issue(2'd1, ra, rb);
        lo_we = 1'b1; hilo_wdata = 32'h0000_0055;
        #1;
        chk("mtlo stall", {63'b0, stall}, 64'd1);
        n = 1;
        while (busy === 1'b1 && n < 40) begin tick(); n++; end
        chk("mtlo wait", 64'(n), 64'd34);
        chk("mtlo pre_lo", {32'b0, lo}, {32'b0, mlo});
        tick();
        lo_we = 1'b0; mlo = 32'h0000_0055;
        chk("mtlo lo", {32'b0, lo}, {32'b0, mlo});
        chk("mtlo hi", {32'b0, hi}, {32'b0, mhi});

        // start while busy is accepted the cycle the unit returns to idle
        model(2'd0, 32'd6, 32'hFFFF_FFFE);
        issue(2'd0, 32'd6, 32'hFFFF_FFFE);
        start = 1'b1; op = 2'd3; src_a = 32'd1000; src_b = 32'd9;
        #1;
        chk("hold stall", {63'b0, stall}, 64'd1);
        n = 1;
        while (busy === 1'b1 && n < 40) begin tick(); n++; end
        chk("hold first_lat", 64'(n), 64'd34);
        chk("hold first_lo", {32'b0, lo}, {32'b0, mlo});
        chk("hold first_hi", {32'b0, hi}, {32'b0, mhi});
        tick();
        start = 1'b0;
        model(2'd3, 32'd1000, 32'd9);
        wait_done(34, "hold second");

        // flush mid-calculation: no result, no done
        phi = mhi; plo = mlo;
        issue(2'd0, $urandom, $urandom);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", {63'b0, busy}, 64'd0);
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        chk("flush no_done", 64'(dcnt), 64'd0);
        chk("flush hi", {32'b0, hi}, {32'b0, phi});
        chk("flush lo", {32'b0, lo}, {32'b0, plo});

        // flush in the FIX cycle wins over completion
        issue(2'd1, 32'd11, 32'd13);
        repeat (32) tick();
        flush = 1'b1;
        #1;
        chk("fixflush busy", {63'b0, busy}, 64'd1);
        tick();
        flush = 1'b0;
        chk("fixflush done", {63'b0, done}, 64'd0);
        chk("fixflush lo", {32'b0, lo}, {32'b0, plo});
        chk("fixflush idle", {63'b0, busy}, 64'd0);

        // asynchronous reset mid-divide
        issue(2'd2, 32'hDEAD_BEEF, 32'd3);
        repeat (19) tick();
        rst = 1'b0;
        #1;
        chk("arst hi", {32'b0, hi}, 64'd0);
        chk("arst lo", {32'b0, lo}, 64'd0);
        chk("arst busy", {63'b0, busy}, 64'd0);
        chk("arst done", {63'b0, done}, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        mhi = '0; mlo = '0;
        run_op(2'd3, 32'd100, 32'd7, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
